// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared op, status and state encodings for the ATM transaction engine
package atm_pkg;

   localparam int          NUM_ACCTS_DEF    = 16;
   localparam logic [31:0] MAX_WITHDRAW_DEF = 32'd1000;

   typedef enum logic [1:0] {
      OP_QUERY    = 2'd0,
      OP_DEPOSIT  = 2'd1,
      OP_WITHDRAW = 2'd2,
      OP_TRANSFER = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_OK           = 3'd0,
      ST_INSUFFICIENT = 3'd1,
      ST_OVERFLOW     = 3'd2,
      ST_LIMIT        = 3'd3,
      ST_BAD_AMOUNT   = 3'd4,
      ST_BAD_ACCT     = 3'd5
   } status_e;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD_A = 3'd1,
      S_RD_B = 3'd2,
      S_EXEC = 3'd3,
      S_WR_A = 3'd4,
      S_WR_B = 3'd5,
      S_DONE = 3'd6
   } state_e;

endpackage

// File: rtl/atm_txn_check.sv
// rtl/atm_txn_check.sv - combinational rule check and balance arithmetic for one transaction
module atm_txn_check
   import atm_pkg::*;
#(
   parameter logic [31:0] MAX_WITHDRAW = MAX_WITHDRAW_DEF
) (
   input  op_e         op,
   input  logic [31:0] amount,
   input  logic [31:0] bal_a,
   input  logic [31:0] bal_b,
   input  logic        acct_a_ok,
   input  logic        acct_b_ok,
   output status_e     status,
   output logic [31:0] new_a,
   output logic [31:0] new_b,
   output logic [31:0] balance
);

   logic [32:0] sum_a;
   logic [32:0] sum_b;
   logic        is_debit;

   // Candidate balances, then the ordered rule checks (first failing rule wins)
   always_comb begin
      sum_a    = {1'b0, bal_a} + {1'b0, amount};
      sum_b    = {1'b0, bal_b} + {1'b0, amount};
      is_debit = (op == OP_WITHDRAW) || (op == OP_TRANSFER);
      new_a    = bal_a;
      new_b    = bal_b;
      status   = ST_OK;

      case (op)
         OP_DEPOSIT:  new_a = sum_a[31:0];
         OP_WITHDRAW: new_a = bal_a - amount;
         OP_TRANSFER: begin
            new_a = bal_a - amount;
            new_b = sum_b[31:0];
         end
         default:     new_a = bal_a;
      endcase

      if (!acct_a_ok || ((op == OP_TRANSFER) && !acct_b_ok)) begin
         status = ST_BAD_ACCT;
      end else if ((op != OP_QUERY) && (amount == 32'd0)) begin
         status = ST_BAD_AMOUNT;
      end else if (is_debit && (amount > MAX_WITHDRAW)) begin
         status = ST_LIMIT;
      end else if (is_debit && (amount > bal_a)) begin
         status = ST_INSUFFICIENT;
      end else if (((op == OP_DEPOSIT) && sum_a[32]) ||
                   ((op == OP_TRANSFER) && sum_b[32])) begin
         status = ST_OVERFLOW;
      end

      // A read from an invalid source index is meaningless, so report zero
      if (!acct_a_ok) begin
         balance = 32'd0;
      end else if (status == ST_OK) begin
         balance = new_a;
      end else begin
         balance = bal_a;
      end
   end

endmodule

// File: rtl/atm_txn_engine.sv
// rtl/atm_txn_engine.sv - read-modify-write sequencer in front of the account register file
module atm_txn_engine
   import atm_pkg::*;
#(
   parameter int          NUM_ACCTS    = NUM_ACCTS_DEF,
   parameter logic [31:0] MAX_WITHDRAW = MAX_WITHDRAW_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [3:0]  acct_a,
   input  logic [3:0]  acct_b,
   input  logic [31:0] amount,
   output logic        busy,
   output logic        done,
   output logic [2:0]  status,
   output logic [31:0] balance_o,
   output logic        rf_we,
   output logic [3:0]  rf_sel,
   output logic [31:0] rf_wdata,
   input  logic [31:0] rf_rdata
);

   localparam logic [31:0] NUM_ACCTS_W = NUM_ACCTS;

   state_e      state_q, state_d;
   op_e         op_q, op_d;
   logic [3:0]  acct_a_q, acct_a_d;
   logic [3:0]  acct_b_q, acct_b_d;
   logic [31:0] amount_q, amount_d;
   logic [31:0] bal_a_q, bal_a_d;
   logic [31:0] bal_b_q, bal_b_d;
   logic [31:0] new_a_q, new_a_d;
   logic [31:0] new_b_q, new_b_d;
   status_e     status_q, status_d;
   logic [31:0] balance_q, balance_d;

   logic        acct_a_ok;
   logic        acct_b_ok;
   status_e     chk_status;
   logic [31:0] chk_new_a;
   logic [31:0] chk_new_b;
   logic [31:0] chk_balance;

   // Destination must be in range and distinct from the source
   always_comb begin
      acct_a_ok = ({28'd0, acct_a_q} < NUM_ACCTS_W);
      acct_b_ok = ({28'd0, acct_b_q} < NUM_ACCTS_W) && (acct_b_q != acct_a_q);
   end

   atm_txn_check #(
      .MAX_WITHDRAW (MAX_WITHDRAW)
   ) u_check (
      .op        (op_q),
      .amount    (amount_q),
      .bal_a     (bal_a_q),
      .bal_b     (bal_b_q),
      .acct_a_ok (acct_a_ok),
      .acct_b_ok (acct_b_ok),
      .status    (chk_status),
      .new_a     (chk_new_a),
      .new_b     (chk_new_b),
      .balance   (chk_balance)
   );

   // Next-state, field capture and register-file port decode from registered state only
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      acct_a_d  = acct_a_q;
      acct_b_d  = acct_b_q;
      amount_d  = amount_q;
      bal_a_d   = bal_a_q;
      bal_b_d   = bal_b_q;
      new_a_d   = new_a_q;
      new_b_d   = new_b_q;
      status_d  = status_q;
      balance_d = balance_q;
      rf_we     = 1'b0;
      rf_sel    = 4'd0;
      rf_wdata  = 32'd0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d     = op_e'(op);
               acct_a_d = acct_a;
               acct_b_d = acct_b;
               amount_d = amount;
               state_d  = S_RD_A;
            end
         end
         S_RD_A: begin
            rf_sel  = acct_a_q;
            bal_a_d = rf_rdata;
            state_d = (op_q == OP_TRANSFER) ? S_RD_B : S_EXEC;
         end
         S_RD_B: begin
            rf_sel  = acct_b_q;
            bal_b_d = rf_rdata;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            status_d  = chk_status;
            new_a_d   = chk_new_a;
            new_b_d   = chk_new_b;
            balance_d = chk_balance;
            state_d   = S_WR_A;
         end
         S_WR_A: begin
            rf_sel   = acct_a_q;
            rf_wdata = new_a_q;
            rf_we    = (status_q == ST_OK) && (op_q != OP_QUERY);
            state_d  = (op_q == OP_TRANSFER) ? S_WR_B : S_DONE;
         end
         S_WR_B: begin
            rf_sel   = acct_b_q;
            rf_wdata = new_b_q;
            rf_we    = (status_q == ST_OK);
            state_d  = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and latched transaction fields; reset aborts any transaction in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         op_q      <= OP_QUERY;
         acct_a_q  <= 4'd0;
         acct_b_q  <= 4'd0;
         amount_q  <= 32'd0;
         bal_a_q   <= 32'd0;
         bal_b_q   <= 32'd0;
         new_a_q   <= 32'd0;
         new_b_q   <= 32'd0;
         status_q  <= ST_OK;
         balance_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         acct_a_q  <= acct_a_d;
         acct_b_q  <= acct_b_d;
         amount_q  <= amount_d;
         bal_a_q   <= bal_a_d;
         bal_b_q   <= bal_b_d;
         new_a_q   <= new_a_d;
         new_b_q   <= new_b_d;
         status_q  <= status_d;
         balance_q <= balance_d;
      end
   end

   // Front-end outputs come straight from registers
   always_comb begin
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      status    = status_q;
      balance_o = balance_q;
   end

endmodule

// File: doc/atm_txn_engine.md
Name: atm_txn_engine

Overview:
- Transaction sequencer that sits directly upstream of the 16 x 32-bit account register file and is the only agent driving its `we`/`sel`/`data_i` port.
- Accepts one customer transaction at a time: balance query, deposit, withdraw, or transfer.
- Performs read-modify-write on account balances through the register file's single shared read/write port.
- Reports a completion pulse, a status code and the resulting balance to the ATM front-end.

Parameters:
- NUM_ACCTS, 16: number of valid account indices; an index >= NUM_ACCTS is invalid.
- MAX_WITHDRAW, 32'd1000: per-transaction ceiling for withdraw and transfer amounts.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  2  operation: 00 QUERY, 01 DEPOSIT, 10 WITHDRAW, 11 TRANSFER.
- acct_a  in  4  primary account (transfer source).
- acct_b  in  4  transfer destination; ignored for other ops.
- amount  in  32  unsigned transaction amount.
- busy  out  1  high from the cycle after accept through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- status  out  3  result code, valid while done=1 and held afterwards.
- balance_o  out  32  result balance, valid while done=1 and held afterwards.
- rf_we  out  1  register-file write enable.
- rf_sel  out  4  register-file index.
- rf_wdata  out  32  register-file write data.
- rf_rdata  in  32  register-file read data; combinational from rf_sel.

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; latched request fields 0.
  - Reset asserted mid-transaction aborts it; no further writes are issued.
  - The register file shares rst, so balances clear as well.
- Interface timing:
  - rf_* outputs are decoded only from the registered state and latched fields; there is no combinational path from the request inputs to rf_*.
  - rf_* = 0 in every state not listed below.
- Status codes: 0 OK, 1 INSUFFICIENT, 2 OVERFLOW, 3 LIMIT, 4 BAD_AMOUNT, 5 BAD_ACCT.
- Accept: in IDLE with start=1, latch op, acct_a, acct_b and amount. That edge is cycle 0.
  - start is ignored in every other state; there is no queueing.
- Non-transfer path: IDLE -> RD_A -> EXEC -> WR_A -> DONE.
  - done=1 in cycle 4.
  - The next accept is possible in cycle 5.
- Transfer path: IDLE -> RD_A -> RD_B -> EXEC -> WR_A -> WR_B -> DONE.
  - done=1 in cycle 6.
- Per-state behaviour:
  - RD_A: rf_sel=acct_a_q; capture rf_rdata into bal_a at the end of the cycle.
  - RD_B: rf_sel=acct_b_q; capture rf_rdata into bal_b at the end of the cycle.
  - EXEC: compute result and status; no register-file access.
  - WR_A: rf_sel=acct_a_q; rf_wdata=new_a; rf_we=1 only if status=OK and op is not QUERY.
  - WR_B: rf_sel=acct_b_q; rf_wdata=new_b; rf_we=1 only if status=OK.
- Write-state latency is fixed: failed or query transactions still pass through the WR states with rf_we=0.
- Check priority in EXEC, first match wins:
  1. BAD_ACCT: acct_a >= NUM_ACCTS; or, for transfer, acct_b >= NUM_ACCTS or acct_b == acct_a.
  2. BAD_AMOUNT: amount == 0 for any op other than QUERY.
  3. LIMIT: withdraw or transfer with amount > MAX_WITHDRAW.
  4. INSUFFICIENT: withdraw or transfer with amount > bal_a.
  5. OVERFLOW: deposit where bal_a + amount carries out of 32 bits, or transfer where bal_b + amount carries out of 32 bits. Compute the sum at 33-bit width.
  6. Otherwise OK.
- Transfers are atomic: either both writes occur or neither does.
- Out-of-range account reads: RD_A/RD_B still drive the raw index; the read value is discarded.
- balance_o:
  - QUERY: bal_a.
  - DEPOSIT/WITHDRAW: new_a if OK, otherwise bal_a.
  - TRANSFER: new source balance if OK, otherwise bal_a.
  - BAD_ACCT with acct_a invalid: 0.
- busy falls in the cycle after DONE, back in IDLE.

Decomposition:
- Shared package atm_pkg holds:
  - op encodings (OP_QUERY..OP_TRANSFER).
  - status codes (ST_OK..ST_BAD_ACCT).
  - the FSM state enum.
- Natural sub-module: atm_txn_check. It is purely combinational, takes op, amount, bal_a, bal_b and account validity, and returns status, new_a and new_b.
- The FSM and latches stay in atm_txn_engine.

Test Plan:
1. Reset, then QUERY acct 3 -> done at cycle 4; status 0; balance_o 0; no rf_we pulses.
2. DEPOSIT 500 to acct 3, then WITHDRAW 200 from acct 3 -> first done: status 0, balance_o 500; second done: status 0, balance_o 300. One rf_we pulse each, in WR_A, with sel=3.
3. WITHDRAW 400 from acct 3 (balance 300) -> status 1, balance_o 300, rf_we never high. Then WITHDRAW 1001 -> status 3 (LIMIT wins over INSUFFICIENT).
4. Preload acct 5 = 0xFFFF_FFF0 via deposits, DEPOSIT 0x20 -> status 2, acct 5 unchanged. DEPOSIT 0 -> status 4.
5. TRANSFER 100 from acct 3 (300) to acct 7 (0) -> done at cycle 6; rf_we in WR_A (sel 3, data 200) and WR_B (sel 7, data 100). TRANSFER 3->3 -> status 5, no writes.
6. Assert start during busy -> ignored. Assert rst in WR_A of a transfer -> outputs 0 immediately, state IDLE, no write to either account.
